// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: runs beside cpu_top and watches the core's PC and
// register-write strobe. While the monitor is running it takes one sample
// per clock into a circular trace buffer. It keeps saturating statistics
// counters and flags misaligned PCs and PCs that stay the same for too long.
// On a selected trigger it freezes so the trace can be read out afterwards.
//
// Handshake note: there is no valid/ready traffic. A sample is taken on
// every posedge where state=RUN, enable=1 and clear=0. Readout has a fixed
// latency: rd_idx is presented, and rd_pc/rd_wr show that entry after the
// next posedge.
module cpu_trace_monitor #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 16,
    parameter int ALIGN_BITS = 2,
    parameter int HANG_LIMIT = 64,
    parameter int CNT_W      = 32,
    parameter int TRIG_MODE  = 3,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [XLEN-1:0]  pc_in,
    input  logic             reg_wr_in,
    input  logic [AW-1:0]    rd_idx,
    output logic [XLEN-1:0]  rd_pc,
    output logic             rd_wr,
    output logic [AW:0]      count,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] misalign_cnt,
    output logic [XLEN-1:0]  first_misalign_pc,
    output logic             hang,
    output logic [1:0]       state
);

    // The repeat counter saturates at HANG_LIMIT, so it only needs enough
    // bits to hold that value.
    localparam int RW = $clog2(HANG_LIMIT + 1);
    localparam bit TRIG_MIS  = (TRIG_MODE == 1) || (TRIG_MODE == 3);
    localparam bit TRIG_HANG = (TRIG_MODE == 2) || (TRIG_MODE == 3);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    state_t            state_q;

    logic [XLEN:0]     mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW:0]       count_q, count_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  misalign_cnt_q, misalign_cnt_d;
    logic [XLEN-1:0]   first_misalign_pc_q, first_misalign_pc_d;
    logic              hang_q, hang_d;
    logic [RW-1:0]     rep_q, rep_d;
    logic [XLEN-1:0]   prev_pc_q, prev_pc_d;
    logic              prev_valid_q, prev_valid_d;
    logic [XLEN-1:0]   rd_pc_q, rd_pc_d;
    logic              rd_wr_q, rd_wr_d;

    logic              sample;
    logic              misaligned;
    logic              mis_hit;
    logic              hang_hit;
    logic              trig;
    logic [AW-1:0]     rd_addr;
    logic              rd_in_range;

    // A misaligned PC has a nonzero value in any of the low ALIGN_BITS bits.
    // When ALIGN_BITS is 0, the check is turned off.
    generate
        if (ALIGN_BITS > 0) begin : g_align
            assign misaligned = |pc_in[ALIGN_BITS-1:0];
        end else begin : g_no_align
            assign misaligned = 1'b0;
        end
    endgenerate

    // clear has priority over a sample. RUN with enable low is the edge that
    // returns to IDLE, so no sample is taken on that edge.
    assign sample   = (state_q == ST_RUN) && enable && !clear;
    assign mis_hit  = sample && misaligned;
    assign hang_hit = sample && (rep_d == RW'(HANG_LIMIT));
    assign trig     = (TRIG_MIS && mis_hit) || (TRIG_HANG && hang_hit);

    // Control FSM: clear first, then trigger, then enable. FROZEN only
    // leaves on clear or reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else if (clear) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (enable) state_q <= ST_RUN;
                ST_RUN: begin
                    if (trig)         state_q <= ST_FROZEN;
                    else if (!enable) state_q <= ST_IDLE;
                end
                ST_FROZEN: state_q <= ST_FROZEN;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    // Next-state logic for the counters, pointers, flags and hang tracker.
    always_comb begin
        wptr_d              = wptr_q;
        count_d             = count_q;
        cycle_cnt_d         = cycle_cnt_q;
        wr_cnt_d            = wr_cnt_q;
        misalign_cnt_d      = misalign_cnt_q;
        first_misalign_pc_d = first_misalign_pc_q;
        hang_d              = hang_q;
        rep_d               = rep_q;
        prev_pc_d           = prev_pc_q;
        prev_valid_d        = prev_valid_q;

        if (clear) begin
            wptr_d              = '0;
            count_d             = '0;
            cycle_cnt_d         = '0;
            wr_cnt_d            = '0;
            misalign_cnt_d      = '0;
            first_misalign_pc_d = '0;
            hang_d              = 1'b0;
            rep_d               = '0;
            prev_valid_d        = 1'b0;
        end else if (state_q != ST_RUN) begin
            // Outside RUN, the repeat tracker stays zeroed. This way each
            // run starts fresh on the IDLE->RUN edge.
            rep_d        = '0;
            prev_valid_d = 1'b0;
        end else if (sample) begin
            wptr_d = wptr_q + 1'b1;
            if (count_q != (AW+1)'(DEPTH)) count_d = count_q + 1'b1;
            if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 1'b1;
            if (reg_wr_in && wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 1'b1;
            if (misaligned) begin
                if (misalign_cnt_q == '0) first_misalign_pc_d = pc_in;
                if (misalign_cnt_q != '1) misalign_cnt_d = misalign_cnt_q + 1'b1;
            end
            if (prev_valid_q && (pc_in == prev_pc_q)) begin
                if (rep_q != RW'(HANG_LIMIT)) rep_d = rep_q + 1'b1;
            end else begin
                rep_d = '0;
            end
            prev_pc_d    = pc_in;
            prev_valid_d = 1'b1;
            if (rep_d == RW'(HANG_LIMIT)) hang_d = 1'b1;
        end
    end

    // rd_idx counts from the oldest valid entry. Indexes past count read
    // back as zero.
    assign rd_addr     = wptr_q - count_q[AW-1:0] + rd_idx;
    assign rd_in_range = ({1'b0, rd_idx} < count_q);

    // Next-state logic for the readout registers. They work in every state.
    always_comb begin
        rd_pc_d = '0;
        rd_wr_d = 1'b0;
        if (rd_in_range) begin
            rd_pc_d = mem_q[rd_addr][XLEN-1:0];
            rd_wr_d = mem_q[rd_addr][XLEN];
        end
    end

    // Trace storage. There is no reset because count alone marks which
    // entries are valid.
    always_ff @(posedge clk) begin
        if (!reset && sample) begin
            mem_q[wptr_q] <= {reg_wr_in, pc_in};
        end
    end

    // State registers for the datapath and readout.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q              <= '0;
            count_q             <= '0;
            cycle_cnt_q         <= '0;
            wr_cnt_q            <= '0;
            misalign_cnt_q      <= '0;
            first_misalign_pc_q <= '0;
            hang_q              <= 1'b0;
            rep_q               <= '0;
            prev_pc_q           <= '0;
            prev_valid_q        <= 1'b0;
            rd_pc_q             <= '0;
            rd_wr_q             <= 1'b0;
        end else begin
            wptr_q              <= wptr_d;
            count_q             <= count_d;
            cycle_cnt_q         <= cycle_cnt_d;
            wr_cnt_q            <= wr_cnt_d;
            misalign_cnt_q      <= misalign_cnt_d;
            first_misalign_pc_q <= first_misalign_pc_d;
            hang_q              <= hang_d;
            rep_q               <= rep_d;
            prev_pc_q           <= prev_pc_d;
            prev_valid_q        <= prev_valid_d;
            rd_pc_q             <= rd_pc_d;
            rd_wr_q             <= rd_wr_d;
        end
    end

    assign rd_pc             = rd_pc_q;
    assign rd_wr             = rd_wr_q;
    assign count             = count_q;
    assign cycle_cnt         = cycle_cnt_q;
    assign wr_cnt            = wr_cnt_q;
    assign misalign_cnt      = misalign_cnt_q;
    assign first_misalign_pc = first_misalign_pc_q;
    assign hang              = hang_q;
    assign state             = state_q;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Testbench for cpu_trace_monitor. Directed vectors with expected values
// worked out by hand. Expectations go into a queue along with the cycle
// they are due. A monitor checks each one on the falling edge of that cycle.
module tb_cpu_trace_monitor;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CNT_W = 5;

    localparam int F_STATE = 0;
    localparam int F_COUNT = 1;
    localparam int F_CYC   = 2;
    localparam int F_WR    = 3;
    localparam int F_MIS   = 4;
    localparam int F_FMP   = 5;
    localparam int F_HANG  = 6;
    localparam int F_RDPC  = 7;
    localparam int F_RDWR  = 8;

    logic             clk = 1'b0;
    logic             reset, enable, clear, reg_wr_in;
    logic [XLEN-1:0]  pc_in;
    logic [AW-1:0]    rd_idx;
    logic [XLEN-1:0]  rd_pc, first_misalign_pc;
    logic             rd_wr, hang;
    logic [AW:0]      count;
    logic [CNT_W-1:0] cycle_cnt, wr_cnt, misalign_cnt;
    logic [1:0]       state;

    typedef struct {
        int          id;
        longint      due;
        logic [63:0] exp;
    } exp_t;

    exp_t   exp_q[$];
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;

    cpu_trace_monitor #(
        .XLEN(XLEN), .DEPTH(DEPTH), .ALIGN_BITS(2), .HANG_LIMIT(8),
        .CNT_W(CNT_W), .TRIG_MODE(3)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .pc_in(pc_in), .reg_wr_in(reg_wr_in), .rd_idx(rd_idx),
        .rd_pc(rd_pc), .rd_wr(rd_wr), .count(count), .cycle_cnt(cycle_cnt),
        .wr_cnt(wr_cnt), .misalign_cnt(misalign_cnt),
        .first_misalign_pc(first_misalign_pc), .hang(hang), .state(state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] get_field(int id);
        case (id)
            F_STATE: return 64'(state);
            F_COUNT: return 64'(count);
            F_CYC:   return 64'(cycle_cnt);
            F_WR:    return 64'(wr_cnt);
            F_MIS:   return 64'(misalign_cnt);
            F_FMP:   return 64'(first_misalign_pc);
            F_HANG:  return 64'(hang);
            F_RDPC:  return 64'(rd_pc);
            F_RDWR:  return 64'(rd_wr);
            default: return 64'hdead;
        endcase
    endfunction

    function automatic string fname(int id);
        case (id)
            F_STATE: return "state";
            F_COUNT: return "count";
            F_CYC:   return "cycle_cnt";
            F_WR:    return "wr_cnt";
            F_MIS:   return "misalign_cnt";
            F_FMP:   return "first_misalign_pc";
            F_HANG:  return "hang";
            F_RDPC:  return "rd_pc";
            F_RDWR:  return "rd_wr";
            default: return "unknown";
        endcase
    endfunction

    // Scoreboard monitor: compares every expectation that is due
    always @(negedge clk) begin
        int i;
        logic [63:0] act;
        i = 0;
        while (i < exp_q.size()) begin
            if (exp_q[i].due <= cyc) begin
                act = get_field(exp_q[i].id);
                checks++;
                if (act !== exp_q[i].exp) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h",
                             fname(exp_q[i].id), cyc, act, exp_q[i].exp);
                end
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(int id, logic [63:0] v);
        exp_t e;
        e.id = id; e.due = cyc; e.exp = v;
        exp_q.push_back(e);
    endtask

    task automatic expect_next(int id, logic [63:0] v);
        exp_t e;
        e.id = id; e.due = cyc + 1; e.exp = v;
        exp_q.push_back(e);
    endtask

    task automatic do_sample(logic [XLEN-1:0] pc, logic wr);
        pc_in = pc;
        reg_wr_in = wr;
        step();
    endtask

    task automatic do_clear();
        enable = 1'b0; clear = 1'b1; step();
        clear = 1'b0; enable = 1'b1; step();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0;
        pc_in = '0; reg_wr_in = 1'b0; rd_idx = '0;
        step(); step();
        reset = 1'b0;
        expect_now(F_STATE, 0); expect_now(F_COUNT, 0); expect_now(F_CYC, 0);
        expect_now(F_HANG, 0);  expect_now(F_RDPC, 0);

        // 1: 20 ascending samples wrap a 16-entry buffer
        enable = 1'b1; step();
        for (int i = 0; i < 20; i++) do_sample(XLEN'(4 * i), 1'b0);
        enable = 1'b0;
        rd_idx = 4'd0;
        expect_now(F_COUNT, 16); expect_now(F_CYC, 20); expect_now(F_STATE, 1);
        expect_next(F_RDPC, 64'h10);
        step();
        rd_idx = 4'd15;
        expect_now(F_STATE, 0);
        expect_next(F_RDPC, 64'h4C);
        step();

        // 2: alternating reg-write strobe
        do_clear();
        for (int i = 0; i < 10; i++) do_sample(XLEN'(32'h1000 + 4 * i), (i % 2) == 0);
        enable = 1'b0; reg_wr_in = 1'b0;
        expect_now(F_WR, 5); expect_now(F_CYC, 10); expect_now(F_COUNT, 10);
        for (int i = 0; i <= 10; i++) begin
            rd_idx = AW'(i);
            expect_next(F_RDPC, (i < 10) ? 64'(32'h1000 + 4 * i) : 64'h0);
            expect_next(F_RDWR, (i < 10) ? 64'((i % 2) == 0) : 64'h0);
            step();
        end

        // 3: misaligned PC freezes; the next PC is not recorded
        do_clear();
        do_sample(32'h100, 1'b0);
        do_sample(32'h104, 1'b0);
        do_sample(32'h106, 1'b0);
        pc_in = 32'h108;
        expect_now(F_STATE, 2); expect_now(F_MIS, 1); expect_now(F_FMP, 64'h106);
        expect_now(F_COUNT, 3); expect_now(F_CYC, 3); expect_now(F_HANG, 0);
        step();
        expect_now(F_STATE, 2); expect_now(F_COUNT, 3); expect_now(F_CYC, 3);
        rd_idx = 4'd2;
        expect_next(F_RDPC, 64'h106);
        step();
        rd_idx = 4'd3;
        expect_next(F_RDPC, 64'h0);
        step();

        // 4: PC held for HANG_LIMIT repeats gives hang on the 9th sample
        clear = 1'b1; enable = 1'b1; step();
        clear = 1'b0;
        expect_now(F_STATE, 0); expect_now(F_COUNT, 0); expect_now(F_MIS, 0);
        expect_now(F_FMP, 0);
        step();
        expect_now(F_STATE, 1); expect_now(F_CYC, 0);
        for (int i = 1; i <= 9; i++) begin
            do_sample(32'h200, 1'b0);
            if (i == 8) begin
                expect_now(F_HANG, 0); expect_now(F_STATE, 1); expect_now(F_CYC, 8);
            end
        end
        expect_now(F_HANG, 1); expect_now(F_STATE, 2); expect_now(F_CYC, 9);
        expect_now(F_COUNT, 9);
        step();
        expect_now(F_CYC, 9); expect_now(F_STATE, 2);

        // 5: counters hold while IDLE; clear and enable together
        do_clear();
        for (int i = 0; i < 5; i++) do_sample(XLEN'(32'h300 + 4 * i), 1'b1);
        enable = 1'b0; reg_wr_in = 1'b0;
        repeat (4) step();
        expect_now(F_STATE, 0); expect_now(F_CYC, 5); expect_now(F_WR, 5);
        expect_now(F_COUNT, 5);
        clear = 1'b1; enable = 1'b1; step();
        clear = 1'b0;
        expect_now(F_STATE, 0); expect_now(F_CYC, 0); expect_now(F_COUNT, 0);
        expect_now(F_WR, 0);
        step();
        expect_now(F_STATE, 1); expect_now(F_CYC, 0);

        // 6: fill buffer, freeze on misalign, then reset while FROZEN
        for (int i = 0; i < 16; i++) do_sample(XLEN'(32'h400 + 4 * i), 1'b0);
        do_sample(32'h441, 1'b0);
        expect_now(F_STATE, 2); expect_now(F_COUNT, 16); expect_now(F_CYC, 17);
        expect_now(F_MIS, 1); expect_now(F_FMP, 64'h441);
        rd_idx = 4'd0;
        expect_next(F_RDPC, 64'h404);
        step();
        rd_idx = 4'd15;
        expect_next(F_RDPC, 64'h441);
        step();
        reset = 1'b1; enable = 1'b0; rd_idx = 4'd0;
        step();
        reset = 1'b0;
        expect_now(F_STATE, 0); expect_now(F_COUNT, 0); expect_now(F_CYC, 0);
        expect_now(F_WR, 0);    expect_now(F_MIS, 0);   expect_now(F_FMP, 0);
        expect_now(F_HANG, 0);  expect_now(F_RDPC, 0);  expect_now(F_RDWR, 0);
        expect_next(F_RDPC, 0);
        step();

        // 7: statistics counters saturate at all-ones
        enable = 1'b1; step();
        for (int i = 0; i < 40; i++) do_sample(XLEN'(32'h800 + 4 * i), 1'b1);
        enable = 1'b0; reg_wr_in = 1'b0;
        expect_now(F_CYC, 31); expect_now(F_WR, 31); expect_now(F_COUNT, 16);
        expect_now(F_MIS, 0);
        rd_idx = 4'd15;
        expect_next(F_RDPC, 64'(32'h800 + 4 * 39));
        step();

        // Drain the scoreboard, which is bounded by a cycle budget
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) step();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
